i2s_tx: RTL
===========

// Module: i2s_tx
// PURPOSE
// Serial I2S transmitter at the output end of the filter chain. It takes one
// signed stereo sample pair (left/right) per frame through a valid/ready
// handshake and serialises it MSB-first. It drives the bit clock (bclk), word
// select (lrclk) and serial data (sdata) toward the DAC. A one-deep input
// buffer plus a frame shadow register decouple the filter sample rate from
// the frame timing.
// PARAMETERS
// WD         24  sample width, two's complement
// SLOT_BITS  32  bclk periods per channel slot; must be >= WD+1
// BCLK_DIV   4   clk cycles per bclk period; must be even and >= 2
// PORTS
// clk       in   1   system clock
// reset_n   in   1   asynchronous, active-low reset
// s_left    in   WD  left-channel sample
// s_right   in   WD  right-channel sample
// s_valid   in   1   sample pair valid
// s_ready   out  1   input buffer empty, pair will be accepted
// bclk      out  1   I2S bit clock, clk/BCLK_DIV
// lrclk     out  1   word select: 0 = left slot, 1 = right slot
// sdata     out  1   serial data, MSB first, one-bclk I2S delay
// underrun  out  1   one-clk pulse: frame started with no data available
// BEHAVIOUR
// - Reset (async): div_cnt=0, bit_cnt=0, buffer empty, shadow=0.
//   Outputs: bclk=0, lrclk=0, sdata=0, s_ready=1, underrun=0.
//   Counters and outputs are flops. Outputs change only on clk edges.
// - div_cnt counts 0..BCLK_DIV-1 and wraps.
//   bclk=0 while div_cnt < BCLK_DIV/2, else 1.
// - bit_cnt advances when div_cnt wraps and counts 0..2*SLOT_BITS-1.
//   lrclk = (bit_cnt >= SLOT_BITS). p = bit_cnt mod SLOT_BITS.
// - sdata at p=0: 0. At p=1..WD: bit WD-p of the slot word (left for
//   lrclk=0, right for lrclk=1). At p > WD: 0.
// - lrclk and sdata change only together with the bclk falling edge.
// - Period k after reset release covers clk cycles k*BCLK_DIV .. k*BCLK_DIV+BCLK_DIV-1.
//   The first frame transmits shadow=0. underrun is not raised for the first frame.
// - Handshake: a transfer occurs when s_valid && s_ready on a clk edge. The
//   pair goes into the buffer and s_ready=0 from the next cycle.
//   s_ready = buffer empty. Data is never dropped or overwritten.
// - Frame wrap: the edge where div_cnt=BCLK_DIV-1 and bit_cnt=2*SLOT_BITS-1.
//   * buffer full: buffer moves to shadow, buffer becomes empty, s_ready=1 next cycle.
//   * buffer empty and a transfer on the same edge: the pair bypasses
//     straight into shadow, the buffer stays empty, no underrun.
//   * buffer empty and no transfer: shadow <= 0 (silence frame), underrun=1
//     for exactly that next cycle.
// - The shadow is stable for the whole frame. Input changes never disturb
//   the frame in progress.
// - Reset asserted mid-frame: all state clears immediately and the buffered
//   sample is discarded. After release, transmission restarts at period 0.
// - No arithmetic. Words are passed bit-exact.
// TESTING
// Use WD=24, SLOT_BITS=32, BCLK_DIV=4 (frame = 64 bclk = 256 clk).
// 1 Reset release, s_valid=0 -> bclk toggles 2 low/2 high; lrclk toggles every 128 clk.
//   sdata=0 throughout frame 0. underrun pulses 1 clk at the end of frame 0.
// 2 Load L=0x800001, R=0x7FFFFF before wrap 0 -> frame 1 left slot:
//   p1=1, p2..p23=0, p24=1, p0 and p25..31=0. Right slot: p1=0, p2..p24=1, pad=0.
// 3 Handshake: pair A accepted -> s_ready=0 next cycle. s_valid held with
//   pair B -> not taken until the wrap. After wrap s_ready=1, B accepted,
//   A transmitted, B in the following frame.
// 4 Bypass: s_valid with L=0xA5A5A5 exactly on the wrap edge with buffer
//   empty -> no underrun, next frame carries 0xA5A5A5, s_ready stays 1.
// 5 Underrun: skip one frame -> underrun 1-clk pulse, that frame all zeros,
//   next frame carries the new data.
// 6 Reset mid-right-slot with a buffered pair -> outputs 0 at once,
//   s_ready=1, that pair is never transmitted.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S transmitter: serialises one stereo sample pair per frame, MSB first with
// the one-bclk I2S delay, from a one-deep input buffer through a frame shadow.
module i2s_tx #(
   parameter int WD        = 24,
   parameter int SLOT_BITS = 32,
   parameter int BCLK_DIV  = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [WD-1:0] s_left,
   input  logic [WD-1:0] s_right,
   input  logic          s_valid,
   output logic          s_ready,
   output logic          bclk,
   output logic          lrclk,
   output logic          sdata,
   output logic          underrun
);

   localparam int DW = $clog2(BCLK_DIV);
   localparam int BW = $clog2(2 * SLOT_BITS);
   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
   localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
   localparam logic [BW-1:0] SLOT     = BW'(SLOT_BITS);

   logic [DW-1:0] div_cnt, div_nxt;
   logic [BW-1:0] bit_cnt, bit_nxt, p_nxt;
   logic [WD-1:0] buf_l, buf_r, sh_l, sh_r, sh_l_nxt, sh_r_nxt, word;
   logic          div_wrap, frame_wrap, xfer, lr_nxt, sd_nxt;

   always_comb begin
      div_wrap   = (div_cnt == DIV_LAST);
      frame_wrap = div_wrap && (bit_cnt == BIT_LAST);
      xfer       = s_valid && s_ready;
      div_nxt    = div_wrap ? '0 : div_cnt + 1'b1;
      bit_nxt    = bit_cnt;
      if (frame_wrap)
         bit_nxt = '0;
      else if (div_wrap)
         bit_nxt = bit_cnt + 1'b1;

      // s_ready low means the buffer holds a pair; otherwise a same-edge
      // transfer bypasses into the shadow, else the frame goes silent.
      sh_l_nxt = sh_l;
      sh_r_nxt = sh_r;
      if (frame_wrap) begin
         if (!s_ready) begin
            sh_l_nxt = buf_l;
            sh_r_nxt = buf_r;
         end else if (s_valid) begin
            sh_l_nxt = s_left;
            sh_r_nxt = s_right;
         end else begin
            sh_l_nxt = '0;
            sh_r_nxt = '0;
         end
      end

      lr_nxt = (bit_nxt >= SLOT);
      p_nxt  = lr_nxt ? bit_nxt - SLOT : bit_nxt;
      word   = lr_nxt ? sh_r_nxt : sh_l_nxt;
      sd_nxt = 1'b0;
      for (int i = 0; i < WD; i++) begin
         if (p_nxt == BW'(WD - i))
            sd_nxt = word[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt  <= '0;
         bit_cnt  <= '0;
         buf_l    <= '0;
         buf_r    <= '0;
         sh_l     <= '0;
         sh_r     <= '0;
         s_ready  <= 1'b1;
         bclk     <= 1'b0;
         lrclk    <= 1'b0;
         sdata    <= 1'b0;
         underrun <= 1'b0;
      end else begin
         div_cnt  <= div_nxt;
         bit_cnt  <= bit_nxt;
         sh_l     <= sh_l_nxt;
         sh_r     <= sh_r_nxt;
         bclk     <= (div_nxt >= DIV_HALF);
         underrun <= frame_wrap && s_ready && !s_valid;
         if (div_wrap) begin
            lrclk <= lr_nxt;
            sdata <= sd_nxt;
         end
         if (frame_wrap)
            s_ready <= 1'b1;
         else if (xfer) begin
            s_ready <= 1'b0;
            buf_l   <= s_left;
            buf_r   <= s_right;
         end
      end
   end

endmodule
